squeeze_module: RTL and testbench
=================================

SQUEEZE_MODULE -- requirements
Module: squeeze_module

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter R_BLOCK_SIZE SHALL default to 1088 and set the rate in bits; it must be a multiple of 64 and at most 1600.
REQ-003 Parameter OUT_BITS SHALL default to 256 and set the digest or squeeze length in bits; it must be at least 1.
REQ-004 Port CLK  in  1  clock; all state updates on the rising edge.
REQ-005 Port A_RST  in  1  asynchronous active-high reset.
REQ-006 Port STATE_IN  in  [0:1599]  permutation state; meaningful only while STATE_VALID=1.
REQ-007 Port STATE_VALID  in  1  one-cycle pulse: the permutation has finished its rounds and STATE_IN holds the final state.
REQ-008 Port START  in  1  pulse: absorb is complete; begin the squeeze phase.
REQ-009 Port PERM_REQ  out  1  one-cycle pulse requesting one more permutation.
REQ-010 Port DOUT  out  [0:63]  output word.
REQ-011 Port DOUT_VALID  out  1  DOUT holds a valid word.
REQ-012 Port DOUT_READY  in  1  the sink accepts DOUT.
REQ-013 Port DOUT_LAST  out  1  the current word is the final word of the squeeze.
REQ-014 Port BUSY  out  1  high in every state except IDLE.
REQ-015 Port DONE  out  1  one-cycle pulse after the final transfer.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_PERM, SEND and REQ.
REQ-017 IDLE SHALL go to WAIT_PERM when START=1; otherwise it holds.
REQ-018 WAIT_PERM, on STATE_VALID=1, SHALL:
  - capture STATE_IN[0:R_BLOCK_SIZE-1] into the rate buffer;
  - reset the block word index to 0;
  - enter SEND.
REQ-019 DOUT_VALID SHALL rise in the cycle after the capturing STATE_VALID edge, presenting word 0 (capture-to-first-word latency is 1 cycle).
REQ-020 Word k of a block SHALL be buffer bits [64k : 64k+63], with no byte or bit reordering.
REQ-021 A transfer SHALL occur on any rising edge where DOUT_VALID=1 and DOUT_READY=1.
REQ-022 While DOUT_VALID=1 and DOUT_READY=0, DOUT, DOUT_VALID and DOUT_LAST SHALL remain stable.
REQ-023 With DOUT_READY held at 1, the block SHALL transfer one word per cycle, with no bubbles inside a block.
REQ-024 Total words SHALL equal ceil(OUT_BITS/64), tracked by a remaining-words counter of width clog2(words+1).
REQ-025 In the final word, DOUT[0:r-1] SHALL carry data and DOUT[r:63] SHALL be 0, where r = OUT_BITS mod 64 and r is nonzero.
REQ-026 DOUT_LAST SHALL be 1 only while the final word is presented.
REQ-027 After the final transfer, the block SHALL:
  - drop DOUT_VALID;
  - pulse DONE for one cycle on the next clock;
  - return to IDLE.
REQ-028 If the block's last word (index R_BLOCK_SIZE/64-1) transfers while words still remain, the FSM SHALL enter REQ.
REQ-029 REQ SHALL assert PERM_REQ for exactly one cycle, then go to WAIT_PERM.
REQ-030 STATE_VALID SHALL be ignored outside WAIT_PERM.
REQ-031 START SHALL be ignored outside IDLE.
REQ-032 DOUT_VALID SHALL be 0 outside SEND.
REQ-033 If the final word and the block-end coincide, the block SHALL finish without issuing PERM_REQ.

Reset
REQ-034 On A_RST=1, the block SHALL immediately force the FSM to IDLE and clear the buffer and counters.
REQ-035 On A_RST=1, DOUT SHALL be 0.
REQ-036 On A_RST=1, DOUT_VALID, DOUT_LAST, PERM_REQ, BUSY and DONE SHALL all be 0.
REQ-037 Reset asserted mid-squeeze SHALL abandon the squeeze; after release, the block SHALL wait for a new START.

Structure
REQ-038 STATE_SIZE (1600) and Z_WIDTH (64) SHALL come from the shared Keccak constants include, not be redefined locally.
REQ-039 Word indexing and remaining-word tracking SHALL live in a single sub-module, squeeze_word_counter, with outputs BLOCK_END and FINAL.

Verification
REQ-040 Scenario: defaults; START; STATE_VALID with lanes 0..3 = 64'h0123456789ABCDEF+k; READY=1.
  - Response: 4 consecutive words matching lanes 0..3.
  - DOUT_LAST on word 3, DONE on the next cycle.
  - PERM_REQ never asserted.
REQ-041 Scenario: defaults; READY=0 for 3 cycles while word 1 is presented.
  - Response: DOUT holds lane 1 unchanged for those cycles.
  - Word 2 follows only after READY returns to 1.
REQ-042 Scenario: R_BLOCK_SIZE=1344, OUT_BITS=1600.
  - Response: 21 words, then a single PERM_REQ pulse.
  - After a second STATE_VALID: 4 more words, taken from the new state's lanes 0..3, with LAST on word 24.
REQ-043 Scenario: OUT_BITS=200.
  - Response: 4 words.
  - Word 3 carries DOUT[0:7]=lane3[0:7] and DOUT[8:63]=0.
REQ-044 Scenario: A_RST pulse during word 2.
  - Response: all outputs 0 asynchronously, BUSY=0.
  - A subsequent STATE_VALID without START produces no output.
REQ-045 Scenario: STATE_VALID in IDLE, and START pulsed during SEND.
  - Response: both ignored; the word sequence and count are unchanged.

Source files
------------

// File: rtl/squeeze_module_pkg.sv
// Shared Keccak constants and helpers for the squeeze datapath.
// Holds the state/lane widths, the squeeze FSM encoding and small
// elaboration-time helpers used to size counters and masks.
package squeeze_module_pkg;

    // Keccak-f[1600] state width and lane (word) width
    localparam int STATE_SIZE = 1600;
    localparam int Z_WIDTH    = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_PERM = 2'd1,
        ST_SEND      = 2'd2,
        ST_REQ       = 2'd3
    } sq_state_e;

    // Integer ceiling division used to size the total word count
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Width of a word index over a block; at least one bit even for 1-word blocks
    function automatic int idx_width(input int block_words);
        return (block_words > 1) ? $clog2(block_words) : 1;
    endfunction

    // Keep lane bits [0:valid_bits-1]; valid_bits == 0 means a full lane
    function automatic logic [0:Z_WIDTH-1] tail_mask(input int valid_bits);
        logic [0:Z_WIDTH-1] m;
        for (int i = 0; i < Z_WIDTH; i++) begin
            m[i] = (valid_bits == 0) || (i < valid_bits);
        end
        return m;
    endfunction

endpackage

// File: rtl/squeeze_module_word_counter.sv
// Word index within the current rate block and remaining-word count
// for the whole squeeze. Flags the last word of a block (BLOCK_END)
// and the last word of the squeeze (FINAL).
module squeeze_word_counter
    import squeeze_module_pkg::*;
#(
    parameter int BLOCK_WORDS = 17,
    parameter int TOTAL_WORDS = 4
) (
    input  logic                              CLK,
    input  logic                              A_RST,
    input  logic                              INIT,
    input  logic                              LOAD,
    input  logic                              ADVANCE,
    output logic [idx_width(BLOCK_WORDS)-1:0] WORD_IDX,
    output logic                              BLOCK_END,
    output logic                              FINAL
);

    localparam int IDX_W = idx_width(BLOCK_WORDS);
    localparam int REM_W = $clog2(TOTAL_WORDS + 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REM_W-1:0] rem_q, rem_d;

    // Next-state: START loads the total, a new block rewinds the index,
    // each accepted word steps both counters
    always_comb begin
        idx_d = idx_q;
        rem_d = rem_q;
        if (INIT) begin
            rem_d = REM_W'(TOTAL_WORDS);
        end else if (ADVANCE && (rem_q != '0)) begin
            rem_d = rem_q - REM_W'(1);
        end
        if (LOAD) begin
            idx_d = '0;
        end else if (ADVANCE && !BLOCK_END) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Counter registers, cleared immediately by reset
    always_ff @(posedge CLK or posedge A_RST) begin
        if (A_RST) begin
            idx_q <= '0;
            rem_q <= '0;
        end else begin
            idx_q <= idx_d;
            rem_q <= rem_d;
        end
    end

    assign WORD_IDX  = idx_q;
    assign BLOCK_END = (idx_q == IDX_W'(BLOCK_WORDS - 1));
    assign FINAL     = (rem_q == REM_W'(1));

endmodule

// File: rtl/squeeze_module.sv
// Squeeze phase of a Keccak sponge: streams rate lanes out as 64-bit words.
// Latency: first word valid 1 cycle after the capturing STATE_VALID edge.
// Backpressure: DOUT holds while DOUT_READY=0; one word/cycle when ready.
module squeeze_module
    import squeeze_module_pkg::*;
#(
    parameter int R_BLOCK_SIZE = 1088,
    parameter int OUT_BITS     = 256
) (
    input  logic                  CLK,
    input  logic                  A_RST,
    input  logic [0:STATE_SIZE-1] STATE_IN,
    input  logic                  STATE_VALID,
    input  logic                  START,
    output logic                  PERM_REQ,
    output logic [0:Z_WIDTH-1]    DOUT,
    output logic                  DOUT_VALID,
    input  logic                  DOUT_READY,
    output logic                  DOUT_LAST,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int BLOCK_WORDS = R_BLOCK_SIZE / Z_WIDTH;
    localparam int TOTAL_WORDS = ceil_div(OUT_BITS, Z_WIDTH);
    localparam int IDX_W       = idx_width(BLOCK_WORDS);
    localparam logic [0:Z_WIDTH-1] LAST_MASK = tail_mask(OUT_BITS % Z_WIDTH);

    sq_state_e          state_q;
    logic               done_q;
    logic [0:Z_WIDTH-1] rate_q [BLOCK_WORDS];

    logic [IDX_W-1:0]   word_idx;
    logic               block_end;
    logic               final_word;
    logic               xfer;
    logic               cnt_init;
    logic               cnt_load;
    logic [0:Z_WIDTH-1] word_sel;

    assign xfer     = (state_q == ST_SEND) && DOUT_READY;
    assign cnt_init = (state_q == ST_IDLE) && START;
    assign cnt_load = (state_q == ST_WAIT_PERM) && STATE_VALID;

    squeeze_word_counter #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .TOTAL_WORDS (TOTAL_WORDS)
    ) u_word_counter (
        .CLK       (CLK),
        .A_RST     (A_RST),
        .INIT      (cnt_init),
        .LOAD      (cnt_load),
        .ADVANCE   (xfer),
        .WORD_IDX  (word_idx),
        .BLOCK_END (block_end),
        .FINAL     (final_word)
    );

    // Squeeze sequencing, rate capture and the DONE pulse
    always_ff @(posedge CLK or posedge A_RST) begin
        if (A_RST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                rate_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q <= ST_WAIT_PERM;
                    end
                end
                ST_WAIT_PERM: begin
                    if (STATE_VALID) begin
                        for (int i = 0; i < BLOCK_WORDS; i++) begin
                            rate_q[i] <= STATE_IN[i*Z_WIDTH +: Z_WIDTH];
                        end
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (DOUT_READY) begin
                        // Final word wins over block end: no extra permutation
                        if (final_word) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else if (block_end) begin
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT_PERM;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output word: current lane, trailing bits of a partial final word zeroed
    always_comb begin
        word_sel = rate_q[word_idx];
        if (final_word) begin
            word_sel = word_sel & LAST_MASK;
        end
        DOUT = (state_q == ST_SEND) ? word_sel : '0;
    end

    assign DOUT_VALID = (state_q == ST_SEND);
    assign DOUT_LAST  = (state_q == ST_SEND) && final_word;
    assign PERM_REQ   = (state_q == ST_REQ);
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = done_q;

    // State lanes beyond the rate are capacity and never leave the block
    if (R_BLOCK_SIZE < STATE_SIZE) begin : g_capacity
        logic unused_capacity;
        assign unused_capacity = ^STATE_IN[R_BLOCK_SIZE:STATE_SIZE-1];
    end

endmodule

// File: tb/tb_squeeze_module.sv
// Three squeeze instances (default, 1344/1600, 1088/200) share clock, reset,
// state bus and ready; each gets its own START/STATE_VALID so only the
// instance under test moves. Expected words come from a list of states.
module tb_squeeze_module;

    logic             clk = 1'b0;
    logic             a_rst;
    logic [0:1599]    state_in;
    logic             dout_ready;
    logic             start_w [3];
    logic             sv_w    [3];
    logic             preq_w  [3];
    logic             dv_w    [3];
    logic             dl_w    [3];
    logic             busy_w  [3];
    logic             done_w  [3];
    logic [0:63]      dout_w  [3];

    int total_checks = 0;
    int bad_checks   = 0;

    always #5 clk = ~clk;

    squeeze_module u_dut_def (
        .CLK(clk), .A_RST(a_rst), .STATE_IN(state_in), .STATE_VALID(sv_w[0]),
        .START(start_w[0]), .PERM_REQ(preq_w[0]), .DOUT(dout_w[0]), .DOUT_VALID(dv_w[0]),
        .DOUT_READY(dout_ready), .DOUT_LAST(dl_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0])
    );

    squeeze_module #(.R_BLOCK_SIZE(1344), .OUT_BITS(1600)) u_dut_long (
        .CLK(clk), .A_RST(a_rst), .STATE_IN(state_in), .STATE_VALID(sv_w[1]),
        .START(start_w[1]), .PERM_REQ(preq_w[1]), .DOUT(dout_w[1]), .DOUT_VALID(dv_w[1]),
        .DOUT_READY(dout_ready), .DOUT_LAST(dl_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1])
    );

    squeeze_module #(.R_BLOCK_SIZE(1088), .OUT_BITS(200)) u_dut_part (
        .CLK(clk), .A_RST(a_rst), .STATE_IN(state_in), .STATE_VALID(sv_w[2]),
        .START(start_w[2]), .PERM_REQ(preq_w[2]), .DOUT(dout_w[2]), .DOUT_VALID(dv_w[2]),
        .DOUT_READY(dout_ready), .DOUT_LAST(dl_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rate_bits(input int sel);
        return (sel == 1) ? 1344 : 1088;
    endfunction

    function automatic int out_bits(input int sel);
        case (sel)
            1:       return 1600;
            2:       return 200;
            default: return 256;
        endcase
    endfunction

    function automatic logic [0:1599] rand_state();
        logic [0:1599] s;
        for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // Lane k of the state, with lane bits at and beyond r cleared on the
    // final word of a squeeze whose length is not a lane multiple
    function automatic logic [0:63] exp_word(input logic [0:1599] s, input int lane,
                                             input bit is_final, input int r);
        logic [0:63] w;
        w = s[lane*64 +: 64];
        if (is_final && r != 0) begin
            for (int b = r; b < 64; b++) w[b] = 1'b0;
        end
        return w;
    endfunction

    task automatic check_all_zero(input string tag, input int sel);
        chk({tag, "_dout"}, 64'(dout_w[sel]), 64'd0);
        chk({tag, "_dv"},   64'(dv_w[sel]),   64'd0);
        chk({tag, "_last"}, 64'(dl_w[sel]),   64'd0);
        chk({tag, "_preq"}, 64'(preq_w[sel]), 64'd0);
        chk({tag, "_busy"}, 64'(busy_w[sel]), 64'd0);
        chk({tag, "_done"}, 64'(done_w[sel]), 64'd0);
    endtask

    // One full squeeze. ready_mode: 0 always ready, 1 stall 3 cycles on
    // word 1, 2 random stalls. noise: STATE_VALID in IDLE + START in SEND.
    task automatic run_squeeze(input int sel, input int ready_mode,
                               input bit fixed_lanes, input bit noise);
        int bw, tot, r, j, stalls, gap;
        logic [0:1599] st;
        logic [0:1599] states [$];
        bw  = rate_bits(sel) / 64;
        tot = (out_bits(sel) + 63) / 64;
        r   = out_bits(sel) % 64;
        j   = 0;
        if (noise) begin
            state_in = rand_state();
            sv_w[sel] = 1'b1;
            @(negedge clk);
            sv_w[sel] = 1'b0;
            @(negedge clk);
            chk("idle_sv_busy", 64'(busy_w[sel]), 64'd0);
            chk("idle_sv_dv",   64'(dv_w[sel]),   64'd0);
        end
        start_w[sel] = 1'b1;
        @(negedge clk);
        start_w[sel] = 1'b0;
        chk("start_busy", 64'(busy_w[sel]), 64'd1);
        chk("start_dv",   64'(dv_w[sel]),   64'd0);
        while (j < tot) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("wait_dv", 64'(dv_w[sel]), 64'd0);
            end
            st = rand_state();
            if (fixed_lanes) begin
                for (int k = 0; k < 4; k++) st[k*64 +: 64] = 64'h0123456789ABCDEF + 64'(k);
            end
            states.push_back(st);
            state_in  = st;
            sv_w[sel] = 1'b1;
            @(negedge clk);
            sv_w[sel] = 1'b0;
            state_in  = rand_state();
            for (int k = 0; k < bw && j < tot; k++) begin
                case (ready_mode)
                    0:       stalls = 0;
                    1:       stalls = (j == 1) ? 3 : 0;
                    default: stalls = $urandom_range(0, 3);
                endcase
                for (int s = 0; s <= stalls; s++) begin
                    dout_ready   = (s == stalls);
                    start_w[sel] = noise && (j == 1) && (s == 0);
                    chk("word_dv",   64'(dv_w[sel]), 64'd1);
                    chk("word_dout", 64'(dout_w[sel]),
                        64'(exp_word(states[j / bw], k, j == tot - 1, r)));
                    chk("word_last", 64'(dl_w[sel]), 64'(j == tot - 1));
                    chk("word_preq", 64'(preq_w[sel]), 64'd0);
                    @(negedge clk);
                end
                start_w[sel] = 1'b0;
                j++;
            end
            dout_ready = 1'($urandom_range(0, 1));
            if (j < tot) begin
                chk("preq_pulse", 64'(preq_w[sel]), 64'd1);
                chk("preq_dv",    64'(dv_w[sel]),   64'd0);
                @(negedge clk);
                chk("preq_once",  64'(preq_w[sel]), 64'd0);
                chk("preq_busy",  64'(busy_w[sel]), 64'd1);
            end
        end
        chk("done_pulse", 64'(done_w[sel]), 64'd1);
        chk("done_dv",    64'(dv_w[sel]),   64'd0);
        chk("done_busy",  64'(busy_w[sel]), 64'd0);
        chk("done_preq",  64'(preq_w[sel]), 64'd0);
        @(negedge clk);
        chk("done_once",  64'(done_w[sel]), 64'd0);
    endtask

    initial begin
        logic [0:1599] st;
        a_rst      = 1'b1;
        state_in   = '0;
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            sv_w[i]    = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_all_zero("reset", i);
        a_rst = 1'b0;
        @(negedge clk);

        // Known lanes, always ready, then a 3-cycle stall on word 1
        run_squeeze(0, 0, 1'b1, 1'b0);
        run_squeeze(0, 1, 1'b1, 1'b0);
        // Two-block squeeze with PERM_REQ between blocks
        run_squeeze(1, 0, 1'b0, 1'b0);
        run_squeeze(1, 2, 1'b0, 1'b1);
        // Partial final word
        run_squeeze(2, 0, 1'b1, 1'b0);
        run_squeeze(2, 2, 1'b0, 1'b0);
        // Ignored STATE_VALID in IDLE and START in SEND
        run_squeeze(0, 2, 1'b0, 1'b1);

        // Reset while word 2 is presented
        st = rand_state();
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        state_in   = st;
        sv_w[0]    = 1'b1;
        @(negedge clk);
        sv_w[0]    = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pre_dv",   64'(dv_w[0]),   64'd1);
        chk("rst_pre_dout", 64'(dout_w[0]), 64'(exp_word(st, 2, 1'b0, 0)));
        #2 a_rst = 1'b1;
        #1 check_all_zero("async_rst", 0);
        @(negedge clk);
        a_rst     = 1'b0;
        state_in  = rand_state();
        sv_w[0]   = 1'b1;
        @(negedge clk);
        sv_w[0]   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_dv",   64'(dv_w[0]),   64'd0);
            chk("post_rst_busy", 64'(busy_w[0]), 64'd0);
            @(negedge clk);
        end
        // Fresh START works after the abandoned squeeze
        run_squeeze(0, 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
